// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS register-file constants
// Provides data width, architectural register indices and the reset
// start addresses of $sp and $gp.
package mips_pkg;
    localparam int N_BITS = 32;
    localparam int REG_ZERO = 0;
    localparam int REG_GP = 28;
    localparam int REG_SP = 29;
    localparam int REG_RA = 31;
    localparam logic [31:0] SP_INIT = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_INIT = 32'h1000_8000;
endpackage

// File: rtl/register_file_cell.sv
// register_cell: N_BITS enable register with synchronous active-low reset
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-low reset, loads RST_VAL
//   i_en   in   load enable
//   i_d    in   data to load
//   o_q    out  stored value
module register_cell #(
    parameter int N_BITS = 32,
    parameter logic [N_BITS-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic [N_BITS-1:0] i_d,
    output logic [N_BITS-1:0] o_q
);
    logic [N_BITS-1:0] r_q;
    always_ff @(posedge clk) begin
        if (!reset) r_q <= RST_VAL;
        else if (i_en) r_q <= i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/register_file.sv
// register_file: MIPS GPR file, two combinational read ports, one synchronous write port
// Ports:
//   clk            in   clock, all state updates on rising edge
//   reset          in   synchronous active-low reset ($gp/$sp get start addresses, others 0)
//   RegWrite       in   write enable
//   WriteRegister  in   write address (0 ignored)
//   WriteData      in   write data
//   ReadRegister1  in   read address, port 1 (ALU A)
//   ReadRegister2  in   read address, port 2 (ALU B)
//   ReadData1      out  contents of ReadRegister1
//   ReadData2      out  contents of ReadRegister2
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through to the read ports.
module register_file
    import mips_pkg::*;
#(
    parameter int N_BITS = mips_pkg::N_BITS,
    parameter int N_REGS = 32,
    parameter logic [N_BITS-1:0] SP_INIT = N_BITS'(mips_pkg::SP_INIT),
    parameter logic [N_BITS-1:0] GP_INIT = N_BITS'(mips_pkg::GP_INIT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [N_BITS-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    output logic [N_BITS-1:0] ReadData1,
    output logic [N_BITS-1:0] ReadData2
);
    logic [N_BITS-1:0] w_q [32];
    logic [31:1]       w_we;
    // Decode starts at 1 so $zero and out-of-range addresses never get an enable.
    always_comb begin
        w_we = '0;
        for (int k = 1; k < 32; k++) w_we[k] = RegWrite && WriteRegister == 5'(k) && k < N_REGS;
    end
    assign w_q[0] = '0;
    for (genvar i = 1; i < 32; i++) begin : g_reg
        if (i < N_REGS) begin : g_cell
            register_cell #(
                .N_BITS (N_BITS),
                .RST_VAL(i == REG_SP ? SP_INIT : i == REG_GP ? GP_INIT : '0)
            ) u_cell (
                .clk  (clk),
                .reset(reset),
                .i_en (w_we[i]),
                .i_d  (WriteData),
                .o_q  (w_q[i])
            );
        end else begin : g_none
            assign w_q[i] = '0;
        end
    end
`ifdef REGFILE_BYPASS_EN
    // |w_we already excludes $zero, out-of-range and disabled writes; reset kills the forward.
    assign ReadData1 = (reset && |w_we && WriteRegister == ReadRegister1) ? WriteData : w_q[ReadRegister1];
    assign ReadData2 = (reset && |w_we && WriteRegister == ReadRegister2) ? WriteData : w_q[ReadRegister2];
`else
    assign ReadData1 = w_q[ReadRegister1];
    assign ReadData2 = w_q[ReadRegister2];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array model
module tb_register_file;
    logic        clk = 1'b0;
    logic        reset, RegWrite;
    logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2;
    logic [31:0] WriteData, ReadData1, ReadData2;
    logic [31:0] m [32];
    logic [31:0] e1, e2;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    // Expected read value given the current inputs and the model contents.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'h0 : m[a];
`ifdef REGFILE_BYPASS_EN
        if (reset && RegWrite && WriteRegister != 5'd0 && WriteRegister == a) v = WriteData;
`endif
        return v;
    endfunction

    // Apply the architectural effect of the upcoming edge to the model, then take the edge.
    task automatic step();
        if (!reset) begin
            foreach (m[k]) m[k] = 32'h0;
            m[28] = 32'h1000_8000;
            m[29] = 32'h7FFF_EFFC;
        end else if (RegWrite && WriteRegister != 5'd0) begin
            m[WriteRegister] = WriteData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 32'h0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        step();
        reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            e1 = (a == 28) ? 32'h1000_8000 : (a == 29) ? 32'h7FFF_EFFC : 32'h0;
            e2 = (31 - a == 28) ? 32'h1000_8000 : (31 - a == 29) ? 32'h7FFF_EFFC : 32'h0;
            n_cmp += 2;
            if (ReadData1 !== e1) begin n_bad++; $display("FAIL reset_rd1 addr %0d got %h want %h", a, ReadData1, e1); end
            if (ReadData2 !== e2) begin n_bad++; $display("FAIL reset_rd2 addr %0d got %h want %h", 31 - a, ReadData2, e2); end
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'hDEAD_BEEF;
        step();
        RegWrite = 1'b0; ReadRegister1 = 5'd8; ReadRegister2 = 5'd0;
        #1;
        n_cmp += 2;
        if (ReadData1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL write8_rd1 got %h want %h", ReadData1, 32'hDEAD_BEEF); end
        if (ReadData2 !== 32'h0) begin n_bad++; $display("FAIL write8_rd2 got %h want %h", ReadData2, 32'h0); end
    endtask

    task automatic test_zero_and_disable();
        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFF_FFFF;
        step();
        RegWrite = 1'b0; ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        #1;
        n_cmp += 2;
        if (ReadData1 !== 32'h0) begin n_bad++; $display("FAIL zero_rd1 got %h want %h", ReadData1, 32'h0); end
        if (ReadData2 !== 32'h0) begin n_bad++; $display("FAIL zero_rd2 got %h want %h", ReadData2, 32'h0); end
        WriteRegister = 5'd9; WriteData = 32'd5;
        step();
        ReadRegister1 = 5'd9;
        #1;
        n_cmp++;
        if (ReadData1 !== 32'h0) begin n_bad++; $display("FAIL no_we_rd9 got %h want %h", ReadData1, 32'h0); end
    endtask

    task automatic test_reset_priority();
        reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd29; WriteData = 32'h1234;
        step();
        reset = 1'b1; RegWrite = 1'b0; ReadRegister1 = 5'd29; ReadRegister2 = 5'd8;
        #1;
        n_cmp += 2;
        if (ReadData1 !== 32'h7FFF_EFFC) begin n_bad++; $display("FAIL rst_prio_sp got %h want %h", ReadData1, 32'h7FFF_EFFC); end
        if (ReadData2 !== 32'h0) begin n_bad++; $display("FAIL rst_clears_r8 got %h want %h", ReadData2, 32'h0); end
        RegWrite = 1'b1;
        step();
        RegWrite = 1'b0;
        #1;
        n_cmp++;
        if (ReadData1 !== 32'h1234) begin n_bad++; $display("FAIL post_rst_write_sp got %h want %h", ReadData1, 32'h1234); end
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 32'd7;
        step();
        WriteData = 32'd9; ReadRegister1 = 5'd10; ReadRegister2 = 5'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        e1 = 32'd9;
`else
        e1 = 32'd7;
`endif
        n_cmp += 2;
        if (ReadData1 !== e1) begin n_bad++; $display("FAIL bypass_pre_edge got %h want %h", ReadData1, e1); end
        if (ReadData2 !== 32'h0) begin n_bad++; $display("FAIL bypass_other_port got %h want %h", ReadData2, 32'h0); end
        WriteRegister = 5'd0; ReadRegister2 = 5'd0;
        #1;
        n_cmp++;
        if (ReadData2 !== 32'h0) begin n_bad++; $display("FAIL zero_no_bypass got %h want %h", ReadData2, 32'h0); end
        WriteRegister = 5'd10;
        step();
        RegWrite = 1'b0;
        #1;
        n_cmp++;
        if (ReadData1 !== 32'd9) begin n_bad++; $display("FAIL bypass_post_edge got %h want %h", ReadData1, 32'd9); end
    endtask

    task automatic test_dual_read();
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 32'h0040_0008;
        step();
        RegWrite = 1'b0; ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        #1;
        n_cmp += 2;
        if (ReadData1 !== 32'h0040_0008) begin n_bad++; $display("FAIL dual_rd1 got %h want %h", ReadData1, 32'h0040_0008); end
        if (ReadData2 !== 32'h0040_0008) begin n_bad++; $display("FAIL dual_rd2 got %h want %h", ReadData2, 32'h0040_0008); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            reset = ($urandom_range(0, 19) != 0);
            RegWrite = 1'($urandom_range(0, 1));
            WriteRegister = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            WriteData = $urandom;
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
            #1;
            e1 = exp_rd(ReadRegister1);
            e2 = exp_rd(ReadRegister2);
            n_cmp += 2;
            if (ReadData1 !== e1) begin n_bad++; $display("FAIL rand_rd1 it %0d addr %0d got %h want %h", it, ReadRegister1, ReadData1, e1); end
            if (ReadData2 !== e2) begin n_bad++; $display("FAIL rand_rd2 it %0d addr %0d got %h want %h", it, ReadRegister2, ReadData2, e2); end
            step();
        end
    endtask

    initial begin
        foreach (m[k]) m[k] = 32'h0;
        test_reset();
        test_write_read();
        test_zero_and_disable();
        test_reset_priority();
        test_bypass();
        test_dual_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
